// File: rtl/alu_pkg.sv
// Shared types for the RV32I EX-stage ALU: opcode encoding and datapath width.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ADD_OP   = 5'd0,
    SUB_OP   = 5'd1,
    AND_OP   = 5'd2,
    OR_OP    = 5'd3,
    XOR_OP   = 5'd4,
    SLL_OP   = 5'd5,
    SRL_OP   = 5'd6,
    SRA_OP   = 5'd7,
    SLT_OP   = 5'd8,
    SLTU_OP  = 5'd9,
    ADDI_OP  = 5'd10,
    ANDI_OP  = 5'd11,
    ORI_OP   = 5'd12,
    XORI_OP  = 5'd13,
    SLLI_OP  = 5'd14,
    SRLI_OP  = 5'd15,
    SRAI_OP  = 5'd16,
    SLTI_OP  = 5'd17,
    SLTIU_OP = 5'd18,
    LUI_OP   = 5'd19
  } alu_op_e;

  localparam logic [4:0] FIRST_ILLEGAL_OP = 5'd20;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter shared by all left/right/arithmetic shift opcodes.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [4:0]      shamt,
  input  logic            dir,    // 1 = left, 0 = right
  input  logic            arith,  // right shifts only: replicate sign bit
  output logic [XLEN-1:0] y
);

  logic [XLEN-1:0] right;

  always_comb begin
    right = arith ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
    y     = dir ? (a << shamt) : right;
  end

endmodule

// File: rtl/riscv_alu.sv
// RV32I integer ALU, one registered output stage (1-cycle latency, no stall).
// Optional ALU_ILLEGAL_OP_EN adds a registered illegal_op flag for opcodes 20..31.
module riscv_alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      opcode,
  output logic            out_valid,
  output logic [XLEN-1:0] result
`ifdef ALU_ILLEGAL_OP_EN
  ,
  output logic            illegal_op
`endif
);

  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shift_res;
  logic            shift_left;
  logic            shift_arith;
  logic            op_illegal;

  assign shift_left  = (opcode == SLL_OP) || (opcode == SLLI_OP);
  assign shift_arith = (opcode == SRA_OP) || (opcode == SRAI_OP);
  assign op_illegal  = (opcode >= FIRST_ILLEGAL_OP);

  alu_shifter u_shifter (
    .a     (operand_a),
    .shamt (operand_b[4:0]),
    .dir   (shift_left),
    .arith (shift_arith),
    .y     (shift_res)
  );

  // I-type opcodes share the R-type datapath; immediates are pre-extended on b.
  always_comb begin
    alu_res = '0;
    case (opcode)
      ADD_OP,  ADDI_OP:  alu_res = operand_a + operand_b;
      SUB_OP:            alu_res = operand_a - operand_b;
      AND_OP,  ANDI_OP:  alu_res = operand_a & operand_b;
      OR_OP,   ORI_OP:   alu_res = operand_a | operand_b;
      XOR_OP,  XORI_OP:  alu_res = operand_a ^ operand_b;
      SLL_OP,  SLLI_OP,
      SRL_OP,  SRLI_OP,
      SRA_OP,  SRAI_OP:  alu_res = shift_res;
      SLT_OP,  SLTI_OP:  alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      SLTU_OP, SLTIU_OP: alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
      LUI_OP:            alu_res = {operand_b[19:0], 12'b0};
      default:           alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) result <= alu_res;
    end
  end

`ifdef ALU_ILLEGAL_OP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        illegal_op <= 1'b0;
    else               illegal_op <= in_valid && op_illegal;
  end
`else
  logic unused_illegal;
  assign unused_illegal = op_illegal;
`endif

endmodule

// File: tb/tb_riscv_alu.sv
// Directed scoreboard bench for riscv_alu: reset, arithmetic, logic, shifts, compares, stream/hold.
module tb_riscv_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  opcode;
  logic        out_valid;
  logic [31:0] result;
`ifdef ALU_ILLEGAL_OP_EN
  logic        illegal_op;
`endif

  riscv_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .result    (result)
`ifdef ALU_ILLEGAL_OP_EN
    ,
    .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic        ill_q[$];
  logic [31:0] last_res = '0;

  // Drive one cycle of stimulus, then check what the output register captured.
  task automatic step(input string tag, input logic v, input logic [4:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] e;
    logic        ie;
    in_valid  = v;
    opcode    = op;
    operand_a = a;
    operand_b = b;
    if (v) begin
      exp_q.push_back(exp);
      ill_q.push_back(op >= 5'd20);
    end
    @(posedge clk);
    #1;
    tests++;
    assert (out_valid === v) else begin
      fails++;
      $error("FAIL %s out_valid: got %b want %b", tag, out_valid, v);
    end
    if (v) begin
      e  = exp_q.pop_front();
      ie = ill_q.pop_front();
      tests++;
      assert (result === e) else begin
        fails++;
        $error("FAIL %s result: got %h want %h", tag, result, e);
      end
      last_res = e;
`ifdef ALU_ILLEGAL_OP_EN
      tests++;
      assert (illegal_op === ie) else begin
        fails++;
        $error("FAIL %s illegal_op: got %b want %b", tag, illegal_op, ie);
      end
`endif
    end else begin
      tests++;
      assert (result === last_res) else begin
        fails++;
        $error("FAIL %s hold: got %h want %h", tag, result, last_res);
      end
    end
  endtask

  initial begin
    // Reset with in_valid high must still clear the outputs.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    opcode    = 5'd0;
    operand_a = 32'd5;
    operand_b = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    assert (result === 32'h0) else begin
      fails++;
      $error("FAIL reset_result: got %h want %h", result, 32'h0);
    end
    tests++;
    assert (out_valid === 1'b0) else begin
      fails++;
      $error("FAIL reset_valid: got %b want %b", out_valid, 1'b0);
    end
`ifdef ALU_ILLEGAL_OP_EN
    tests++;
    assert (illegal_op === 1'b0) else begin
      fails++;
      $error("FAIL reset_illegal: got %b want %b", illegal_op, 1'b0);
    end
`endif
    rst_n = 1'b1;

    // Arithmetic
    step("add",      1, 5'd0,  32'd100,      32'd50,       32'd150);
    step("sub_neg",  1, 5'd1,  -32'sd20,     32'd10,       -32'sd30);
    step("add_ovf",  1, 5'd0,  32'h7FFFFFFF, 32'd2,        32'h80000001);
    step("sub_ovf",  1, 5'd1,  32'h80000000, 32'hFFFFFFFE, 32'h80000002);
    step("addi",     1, 5'd10, 32'd1000,     -32'sd1,      32'd999);
    step("lui",      1, 5'd19, 32'hDEADBEEF, 32'h12345,    32'h12345000);
    step("lui_max",  1, 5'd19, 32'h0,        32'hFFFFF,    32'hFFFFF000);

    // Logic
    step("and",      1, 5'd2,  32'hF00F0F00, 32'h0F00F0F0, 32'h00000000);
    step("or",       1, 5'd3,  32'hF00F0F00, 32'h0F00F0F0, 32'hFF0FFFF0);
    step("andi",     1, 5'd11, 32'hF00F0F00, 32'h00000F00, 32'h00000F00);
    step("xori",     1, 5'd13, 32'hF00F0F00, 32'h00000F0F, 32'hF00F000F);
    step("xor",      1, 5'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555);
    step("ori",      1, 5'd12, 32'h00000001, 32'h00000100, 32'h00000101);

    // Shifts
    step("sll",      1, 5'd5,  32'd256,      32'd2,        32'd1024);
    step("srli",     1, 5'd15, 32'hFFFFFFFF, 32'd1,        32'h7FFFFFFF);
    step("sra",      1, 5'd7,  32'hFFFFFF00, 32'd2,        32'hFFFFFFC0);
    step("sra_31",   1, 5'd7,  32'hFFFFFFFF, 32'd31,       32'hFFFFFFFF);
    step("sra_1_31", 1, 5'd7,  32'h00000001, 32'd31,       32'h00000000);
    step("sll_b33",  1, 5'd5,  32'd1,        32'd33,       32'd2);
    step("srl",      1, 5'd6,  32'h80000000, 32'd31,       32'h00000001);
    step("slli",     1, 5'd14, 32'h00000003, 32'd4,        32'h00000030);
    step("srai",     1, 5'd16, 32'h80000000, 32'd4,        32'hF8000000);

    // Compares
    step("slt_neg",  1, 5'd8,  -32'sd100,    -32'sd50,     32'd1);
    step("slt_pos",  1, 5'd8,  32'd100,      32'd50,       32'd0);
    step("sltu",     1, 5'd9,  -32'sd100,    32'd100,      32'd0);
    step("sltiu",    1, 5'd18, 32'd100,      -32'sd200,    32'd1);
    step("slti",     1, 5'd17, -32'sd1,      32'd0,        32'd1);

    // Stream of three back-to-back ops, then idle cycles holding the result
    step("strm0",    1, 5'd0,  32'd1,        32'd2,        32'd3);
    step("strm1",    1, 5'd1,  32'd10,       32'd4,        32'd6);
    step("strm2",    1, 5'd4,  32'hFF,       32'h0F,       32'hF0);
    step("hold0",    0, 5'd0,  32'd77,       32'd88,       32'd0);
    step("hold1",    0, 5'd1,  32'h12345678, 32'd1,        32'd0);

    // Unassigned opcodes
    step("op25",     1, 5'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    step("op20",     1, 5'd20, 32'd5,        32'd5,        32'd0);
    step("op31",     1, 5'd31, 32'd5,        32'd5,        32'd0);
    step("post_ill", 1, 5'd0,  32'd5,        32'd5,        32'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
